// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Arbitrates the single register-file write port (WE3/A3/WD3) among three
//   writeback requesters: ALU (0), load return (1) and host/debug (2). The
//   winner is registered into a one-deep output stage. Writes to r0 and to
//   addresses at or above NREG are filtered out before they reach the file.
//
//   Build option: define RR_ARB_EN for round-robin selection. Without it,
//   selection is fixed priority, ALU > load > host.
//
//   Ports:
//     clk, rst        clock; asynchronous active-high reset
//     hold            blocks all grants while high
//     req_valid[2:0]  per-requester valid
//     req_ready[2:0]  per-requester ready (one-hot or zero)
//     req_addr        packed addresses, requester i at [i*AW +: AW]
//     req_data        packed data, requester i at [i*DW +: DW]
//     rf_we/wa/wd     register-file write port
//     err_addr        sticky: an out-of-range write was dropped
//     err_clr         synchronous clear of err_addr (set wins)
//     conflict_cnt    saturating count of multi-request cycles with hold=0
module regfile_wr_arbiter #(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NREG = 8,
  parameter int unsigned CW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic [2:0]      req_valid,
  output logic [2:0]      req_ready,
  input  logic [3*AW-1:0] req_addr,
  input  logic [3*DW-1:0] req_data,
  output logic            rf_we,
  output logic [AW-1:0]   rf_wa,
  output logic [DW-1:0]   rf_wd,
  output logic            err_addr,
  input  logic            err_clr,
  output logic [CW-1:0]   conflict_cnt
);

  logic [1:0]    sel;
  logic          any_valid;
  logic          xfer;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          addr_zero;
  logic          addr_oob;

  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_wa_q, rf_wa_d;
  logic [DW-1:0] rf_wd_q, rf_wd_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

`ifdef RR_ARB_EN
  logic [1:0] last_q, last_d;
  logic [1:0] cand;

  // Search last+1, last+2, last+3 (mod 3); the first valid one wins.
  always_comb begin
    sel       = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= 3; k++) begin
      cand = 2'((32'(last_q) + k) % 32'd3);
      if (!any_valid && req_valid[cand]) begin
        sel       = cand;
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (xfer) last_d = sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 2'd2;
    else     last_q <= last_d;
  end
`else
  always_comb begin
    sel       = '0;
    any_valid = 1'b1;
    if (req_valid[0])      sel = 2'd0;
    else if (req_valid[1]) sel = 2'd1;
    else if (req_valid[2]) sel = 2'd2;
    else                   any_valid = 1'b0;
  end
`endif

  // Ready is forced low during reset so nothing is accepted into a stage
  // that is being cleared.
  assign xfer      = any_valid && !hold && !rst;
  assign req_ready = xfer ? (3'b001 << sel) : '0;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    case (sel)
      2'd0:    begin sel_addr = req_addr[0*AW +: AW]; sel_data = req_data[0*DW +: DW]; end
      2'd1:    begin sel_addr = req_addr[1*AW +: AW]; sel_data = req_data[1*DW +: DW]; end
      2'd2:    begin sel_addr = req_addr[2*AW +: AW]; sel_data = req_data[2*DW +: DW]; end
      default: begin sel_addr = '0; sel_data = '0; end
    endcase
  end

  assign addr_zero = (sel_addr == '0);
  assign addr_oob  = (32'(sel_addr) >= NREG);

  always_comb begin
    rf_we_d = xfer && !addr_zero && !addr_oob;
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    if (xfer) begin
      rf_wa_d = sel_addr;
      rf_wd_d = sel_data;
    end
  end

  always_comb begin
    err_d = err_q;
    if (xfer && addr_oob) err_d = 1'b1;
    else if (err_clr)     err_d = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!hold && ($countones(req_valid) >= 2) && (cnt_q != '1))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q <= 1'b0;
      rf_wa_q <= '0;
      rf_wd_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      rf_wa_q <= rf_wa_d;
      rf_wd_q <= rf_wd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_wa        = rf_wa_q;
  assign rf_wd        = rf_wd_q;
  assign err_addr     = err_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter: a table of single-requester vectors,
// then hand-written sequences for contention, hold, reset mid-write and
// counter saturation. A second instance with CW=4 shares the stimulus.
module tb_regfile_wr_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            hold;
  logic            err_clr;
  logic [2:0]      req_valid;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_data;

  logic [2:0]      req_ready, ready_s;
  logic            rf_we, we_s;
  logic [AW-1:0]   rf_wa, wa_s;
  logic [DW-1:0]   rf_wd, wd_s;
  logic            err_addr, err_s;
  logic [15:0]     conflict_cnt;
  logic [3:0]      cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter dut (
    .clk(clk), .rst(rst), .hold(hold), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .err_addr(err_addr), .err_clr(err_clr), .conflict_cnt(conflict_cnt)
  );

  regfile_wr_arbiter #(.CW(4)) dut_sat (
    .clk(clk), .rst(rst), .hold(hold), .req_valid(req_valid), .req_ready(ready_s),
    .req_addr(req_addr), .req_data(req_data), .rf_we(we_s), .rf_wa(wa_s), .rf_wd(wd_s),
    .err_addr(err_s), .err_clr(err_clr), .conflict_cnt(cnt_s)
  );

  // Register-file model fed by the write port.
  logic [DW-1:0] rf_model [8];
  initial for (int i = 0; i < 8; i++) rf_model[i] = '0;
  always @(posedge clk) if (rf_we) rf_model[rf_wa[2:0]] <= rf_wd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; hold = 1'b0; err_clr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0]    valid;
    logic          hold;
    logic          clr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [2:0]    exp_ready;
    logic          exp_we;
    logic [AW-1:0] exp_wa;
    logic [DW-1:0] exp_wd;
    logic          exp_err;
  } vec_t;

  vec_t vt [13];

  logic [2:0]    exp_g;
  logic [AW-1:0] exp_a;

  initial begin
    vt[0]  = '{3'b001, 1'b0, 1'b0, 5'd3,  32'hDEADBEEF, 3'b001, 1'b1, 5'd3,  32'hDEADBEEF, 1'b0};
    vt[1]  = '{3'b000, 1'b0, 1'b0, 5'd3,  32'h00000000, 3'b000, 1'b0, 5'd3,  32'hDEADBEEF, 1'b0};
    vt[2]  = '{3'b010, 1'b0, 1'b0, 5'd7,  32'h11111111, 3'b010, 1'b1, 5'd7,  32'h11111111, 1'b0};
    vt[3]  = '{3'b100, 1'b0, 1'b0, 5'd0,  32'h22222222, 3'b100, 1'b0, 5'd0,  32'h22222222, 1'b0};
    vt[4]  = '{3'b100, 1'b0, 1'b0, 5'd9,  32'h33333333, 3'b100, 1'b0, 5'd9,  32'h33333333, 1'b1};
    vt[5]  = '{3'b000, 1'b0, 1'b1, 5'd0,  32'h00000000, 3'b000, 1'b0, 5'd9,  32'h33333333, 1'b0};
    vt[6]  = '{3'b100, 1'b0, 1'b1, 5'd9,  32'h55555555, 3'b100, 1'b0, 5'd9,  32'h55555555, 1'b1};
    vt[7]  = '{3'b000, 1'b0, 1'b1, 5'd0,  32'h00000000, 3'b000, 1'b0, 5'd9,  32'h55555555, 1'b0};
    vt[8]  = '{3'b001, 1'b1, 1'b0, 5'd2,  32'h44444444, 3'b000, 1'b0, 5'd9,  32'h55555555, 1'b0};
    vt[9]  = '{3'b001, 1'b0, 1'b0, 5'd2,  32'h44444444, 3'b001, 1'b1, 5'd2,  32'h44444444, 1'b0};
    vt[10] = '{3'b100, 1'b0, 1'b0, 5'd8,  32'h66666666, 3'b100, 1'b0, 5'd8,  32'h66666666, 1'b1};
    vt[11] = '{3'b010, 1'b0, 1'b1, 5'd1,  32'h77777777, 3'b010, 1'b1, 5'd1,  32'h77777777, 1'b0};
    vt[12] = '{3'b010, 1'b0, 1'b0, 5'd31, 32'h88888888, 3'b010, 1'b0, 5'd31, 32'h88888888, 1'b1};

    // Reset state, with all requesters valid during reset.
    rst = 1'b1; hold = 1'b0; err_clr = 1'b0;
    req_valid = 3'b111; req_addr = '0; req_data = '0;
    #2;
    check("reset_ready", req_ready, 3'b000);
    check("reset_we", rf_we, 1'b0);
    check("reset_wa", rf_wa, 5'd0);
    check("reset_wd", rf_wd, 32'd0);
    check("reset_err", err_addr, 1'b0);
    check("reset_cnt", conflict_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b0; req_valid = '0;

    // Table vectors: one requester at a time.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      req_valid = vt[i].valid;
      hold      = vt[i].hold;
      err_clr   = vt[i].clr;
      req_addr  = {3{vt[i].addr}};
      req_data  = {3{vt[i].data}};
      #1;
      check($sformatf("v%0d_ready", i), req_ready, vt[i].exp_ready);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_we", i), rf_we, vt[i].exp_we);
      check($sformatf("v%0d_wa", i), rf_wa, vt[i].exp_wa);
      check($sformatf("v%0d_wd", i), rf_wd, vt[i].exp_wd);
      check($sformatf("v%0d_err", i), err_addr, vt[i].exp_err);
    end
    check("rf3_committed", rf_model[3], 32'hDEADBEEF);

    // Contention: all three valid, addresses 1, 2, 4.
    reset_dut();
    req_valid = 3'b111;
    req_addr  = {5'd4, 5'd2, 5'd1};
    req_data  = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    for (int i = 0; i < 7; i++) begin
      exp_g = RR ? (3'b001 << (i % 3)) : 3'b001;
      exp_a = (exp_g == 3'b001) ? 5'd1 : (exp_g == 3'b010) ? 5'd2 : 5'd4;
      #1;
      check($sformatf("cont%0d_ready", i), req_ready, exp_g);
      @(posedge clk);
      #1;
      check($sformatf("cont%0d_wa", i), rf_wa, exp_a);
      check($sformatf("cont%0d_we", i), rf_we, 1'b1);
      if (i == 5) begin
        check("cont_cnt6", conflict_cnt, 16'd6);
        check("cont_cnt6_s", cnt_s, 4'd6);
      end
      @(negedge clk);
    end

    // Hold for 4 cycles with all valid; last grant was requester 0.
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("hold%0d_ready", i), req_ready, 3'b000);
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_we", i), rf_we, 1'b0);
      @(negedge clk);
    end
    check("hold_cnt", conflict_cnt, 16'd7);
    hold = 1'b0;
    #1;
    check("hold_release_ready", req_ready, RR ? 3'b010 : 3'b001);
    @(posedge clk);

    // Reset mid-write: load writes r5, reset hits before the commit edge.
    @(negedge clk);
    req_valid = 3'b010;
    req_addr  = {3{5'd5}};
    req_data  = {3{32'hCAFEF00D}};
    @(posedge clk);
    #1;
    check("midrst_we_before", rf_we, 1'b1);
    check("midrst_wa_before", rf_wa, 5'd5);
    req_valid = 3'b111;
    #1;
    rst = 1'b1;
    #1;
    check("midrst_we", rf_we, 1'b0);
    check("midrst_wa", rf_wa, 5'd0);
    check("midrst_wd", rf_wd, 32'd0);
    check("midrst_ready", req_ready, 3'b000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_addr = {5'd4, 5'd2, 5'd1};
    #1;
    check("postrst_ready", req_ready, 3'b001);
    @(posedge clk);
    #1;
    check("postrst_wa", rf_wa, 5'd1);
    check("r5_unchanged", rf_model[5], 32'd0);

    // Saturation: all valid, 20 counted cycles in total since reset.
    repeat (19) @(posedge clk);
    #1;
    check("sat_cnt16", conflict_cnt, 16'd20);
    check("sat_cnt4", cnt_s, 4'd15);
    repeat (3) @(posedge clk);
    #1;
    check("sat_cnt4_hold", cnt_s, 4'd15);
    check("sat_cnt16_more", conflict_cnt, 16'd23);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the single register-file write port (WE3/A3/WD3) among three writeback requesters: ALU result, load-return data, and the host/debug port. Each requester uses a valid/ready handshake. The winner is registered into a one-deep output stage that drives the register file. Writes to r0 and to addresses outside the 8-entry file are filtered here, so the register file sees only legal writes.

## Interface
Parameters:
- DW, 32, data width; must equal the register-file word width.
- AW, 5, register address width.
- NREG, 8, number of implemented registers; legal addresses are 1..NREG-1.
- CW, 16, width of the conflict counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- hold  in  1  when 1, no grants are issued; all ready outputs are 0.
- req_valid  in  3  per-requester valid. Bit 0 = ALU, bit 1 = load, bit 2 = host.
- req_ready  out  3  per-requester ready; one-hot or zero.
- req_addr  in  3*AW  packed destination addresses; requester i uses bits [i*AW +: AW].
- req_data  in  3*DW  packed write data; requester i uses bits [i*DW +: DW].
- rf_we  out  1  write enable to the register file (WE3).
- rf_wa  out  AW  write address to the register file (A3).
- rf_wd  out  DW  write data to the register file (WD3).
- err_addr  out  1  sticky flag: an out-of-range write was dropped.
- err_clr  in  1  clears err_addr (synchronous).
- conflict_cnt  out  CW  saturating count of cycles with more than one valid request while hold=0.

## Operation
- Grant (combinational):
  - A transfer on requester i occurs when req_valid[i] and req_ready[i] are both 1 at a rising edge.
  - req_ready[i]=1 only for the selected requester, only when hold=0 and req_valid[i]=1.
  - req_ready does not depend on rf_we; the output stage drains every cycle, so there is no backpressure.
- Requester rules:
  - A requester must keep valid, addr and data stable until the transfer occurs.
  - Dropping valid before the transfer is allowed, and that request is lost.
- Selection with RR_ARB_EN defined:
  - Round-robin over a 2-bit pointer `last`, which holds the index of the last granted requester. Reset value is 2.
  - Search order is last+1, last+2, last+3, modulo 3.
  - `last` updates only on a transfer.
- Output stage, on each transfer:
  - rf_wa <= addr and rf_wd <= data.
  - rf_we <= 1 only if addr != 0 and addr < NREG.
  - If addr == 0: the transfer completes (ready was given) but rf_we <= 0. This is not an error.
  - If addr >= NREG: rf_we <= 0 and err_addr <= 1.
- Output stage, with no transfer: rf_we <= 0. rf_wa and rf_wd hold their previous values.
- err_addr:
  - Set has priority over err_clr when both occur in the same cycle.
  - Otherwise err_clr=1 clears it to 0.
- conflict_cnt: increments when hold=0 and popcount(req_valid) >= 2; it saturates at 2^CW-1.
- Reset values: rf_we=0, rf_wa=0, rf_wd=0, err_addr=0, conflict_cnt=0, last=2.
  - A write held in the output stage when reset asserts is discarded and never reaches the register file.
  - req_ready is 0 while rst=1.

## Timing
- Latency: a transfer at edge N drives rf_we/rf_wa/rf_wd during cycle N..N+1. The register file commits at edge N+1, so the data is readable through RD1/RD2 after edge N+1.
- Throughput: one write per cycle, sustained.
- Back-to-back writes to the same address: both are issued in grant order and the later one wins.
- hold is sampled combinationally:
  - Asserting hold in the same cycle as a valid blocks that cycle's grant.
  - A write already in the output stage still commits.
- Read-after-write inside the arbiter is the caller's responsibility: a read at cycle N+1 of an address written at transfer N returns the old value.

## Configuration
- RR_ARB_EN defined: round-robin selection as above; the `last` register exists.
- RR_ARB_EN undefined: fixed priority, ALU (0) > load (1) > host (2). `last` is not implemented; all other behaviour is identical.

## Test plan
- Single write: reset, then ALU valid with addr=3, data=0xDEADBEEF for one cycle. Required: req_ready=001; the next cycle has rf_we=1, rf_wa=3, rf_wd=0xDEADBEEF; the following cycle has rf_we=0.
- Contention (RR_ARB_EN defined): all three valid continuously with distinct addresses 1, 2, 4. Required: grant order 0, 1, 2, 0, 1, 2; conflict_cnt=6 after 6 cycles. Without the macro: requester 0 is granted every cycle.
- Filtering:
  - Host writes addr=0 → ready=1 and rf_we=0; err_addr stays 0.
  - Host then writes addr=9 → rf_we=0 and err_addr=1.
  - err_clr pulse → err_addr=0.
  - err_clr asserted in the same cycle as another addr=9 transfer → err_addr remains 1.
- Hold: hold=1 with all three valid for 4 cycles. Required: req_ready=000, rf_we=0, conflict_cnt unchanged. After release, the first grant goes to pointer+1.
- Reset mid-operation: a transfer at edge N with addr=5, then rst asserted asynchronously before edge N+1. Required: rf_we falls to 0 immediately, register 5 is unchanged, and after reset release the first grant goes to requester 0.
- Saturation: with CW=4, force 20 conflict cycles. Required: conflict_cnt=15 and holds.
